// File: rtl/dcache_port_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : dcache_port_sched_pkg
// Brief  : Shared types and default sizes for the DCache port scheduler.
// Rev    : 1.0  initial release
// ============================================================================
package dcache_port_sched_pkg;

    localparam int c_CACHE_WIDTHE  = 6;
    localparam int c_CACHE_DEEPTHE = 6;
    localparam int c_ADDR_W        = 12;
    localparam int c_SB_DEPTH      = 4;
    localparam int c_STARVE_LIMIT  = 8;

    typedef enum logic [0:0] {
        SB_RUN   = 1'b0,
        SB_FLUSH = 1'b1
    } sb_state_e;

    typedef struct packed {
        logic [c_ADDR_W-1:0]             addr;
        logic [2**c_CACHE_WIDTHE-1:0]    data;
        logic [2**c_CACHE_WIDTHE-1:0]    mask;
    } sb_entry_t;

endpackage
`default_nettype wire

// File: rtl/dcache_port_sched_sb_fifo.sv
`default_nettype none
// ============================================================================
// Module : sb_fifo
// Brief  : Circular store buffer with head read and per-entry address match.
// Rev    : 1.0  initial release
// ============================================================================
module sb_fifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [DATA_W-1:0]            i_data,
    input  logic [DATA_W-1:0]            i_mask,
    input  logic                         i_pop,
    output logic [ADDR_W-1:0]            o_head_addr,
    output logic [DATA_W-1:0]            o_head_data,
    output logic [DATA_W-1:0]            o_head_mask,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty,
    input  logic [ADDR_W-1:0]            i_match_addr,
    output logic [DEPTH-1:0]             o_match
);
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DATA_W-1:0] r_mask [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_wr_ptr] <= i_addr;
            r_data[r_wr_ptr] <= i_data;
            r_mask[r_wr_ptr] <= i_mask;
        end
    end

    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_head_mask = r_mask[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full      = (r_count == c_CW'(DEPTH));
    assign o_empty     = (r_count == '0);

    // An entry is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [c_PW-1:0] w_off;
        assign w_off      = c_PW'(i) - r_rd_ptr;
        assign o_match[i] = ({1'b0, w_off} < r_count) && (r_addr[i] == i_match_addr);
    end

endmodule
`default_nettype wire

// File: rtl/dcache_port_sched.sv
`default_nettype none
// ============================================================================
// Module : dcache_port_sched
// Brief  : Arbitrates the single DCache port between loads and store drain.
// Rev    : 1.0  initial release
// ============================================================================
module dcache_port_sched
    import dcache_port_sched_pkg::*;
#(
    parameter int CACHE_WIDTHE  = c_CACHE_WIDTHE,
    parameter int CACHE_DEEPTHE = c_CACHE_DEEPTHE,
    parameter int ADDR_W        = c_ADDR_W,
    parameter int SB_DEPTH      = c_SB_DEPTH,
    parameter int STARVE_LIMIT  = c_STARVE_LIMIT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          st_valid,
    output logic                          st_ready,
    input  logic [ADDR_W-1:0]             st_addr,
    input  logic [2**CACHE_WIDTHE-1:0]    st_data,
    input  logic [2**CACHE_WIDTHE-1:0]    st_mask,
    input  logic                          ld_valid,
    input  logic [ADDR_W-1:0]             ld_addr,
    output logic                          ld_grant,
    output logic                          ld_stall,
    input  logic                          flush_req,
    output logic                          flush_done,
    output logic                          dc_en,
    output logic                          dc_wr_en,
    output logic [ADDR_W-1:0]             dc_addr,
    output logic [2**CACHE_WIDTHE-1:0]    dc_wr_data,
    output logic [2**CACHE_WIDTHE-1:0]    dc_wr_mask,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count
);
    localparam int c_DW  = 2**CACHE_WIDTHE;
    localparam int c_CW  = $clog2(SB_DEPTH+1);
    localparam int c_SCW = $clog2(STARVE_LIMIT+1);

    if (SB_DEPTH < 2 || (SB_DEPTH & (SB_DEPTH-1)) != 0 || CACHE_DEEPTHE > ADDR_W) begin : g_param_check
        $error("dcache_port_sched: illegal parameter combination");
    end

    sb_state_e        r_state;
    logic [c_SCW-1:0] r_starve;

    logic              w_push;
    logic              w_drain;
    logic              w_load;
    logic              w_conflict;
    logic              w_full;
    logic              w_empty;
    logic [c_CW-1:0]   w_count;
    logic [SB_DEPTH-1:0] w_match;
    logic [ADDR_W-1:0] w_head_addr;
    logic [c_DW-1:0]   w_head_data;
    logic [c_DW-1:0]   w_head_mask;

    sb_fifo #(
        .DEPTH  (SB_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (c_DW)
    ) u_sb_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_addr       (st_addr),
        .i_data       (st_data),
        .i_mask       (st_mask),
        .i_pop        (w_drain),
        .o_head_addr  (w_head_addr),
        .o_head_data  (w_head_data),
        .o_head_mask  (w_head_mask),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .i_match_addr (ld_addr),
        .o_match      (w_match)
    );

    assign st_ready   = !w_full && (r_state == SB_RUN) && !rst;
    assign w_push     = st_valid && st_ready;
    // A store accepted this cycle is not yet in the buffer but still blocks a same-address load.
    assign w_conflict = (|w_match) || (w_push && (st_addr == ld_addr));

    always_comb begin
        w_drain = 1'b0;
        w_load  = 1'b0;
        if (!rst) begin
            if (!w_empty && (r_state == SB_FLUSH || r_starve == c_SCW'(STARVE_LIMIT)))
                w_drain = 1'b1;
            else if (ld_valid && !w_conflict)
                w_load = 1'b1;
            else if (!w_empty)
                w_drain = 1'b1;
        end
    end

    assign ld_grant   = w_load;
    assign ld_stall   = ld_valid && !w_load;
    assign dc_en      = w_load || w_drain;
    assign dc_wr_en   = w_drain;
    assign dc_addr    = w_drain ? w_head_addr : ld_addr;
    assign dc_wr_data = w_drain ? w_head_data : '0;
    assign dc_wr_mask = w_drain ? w_head_mask : '0;
    assign flush_done = !rst && (r_state == SB_FLUSH) && w_empty;
    assign sb_count   = w_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SB_RUN;
            r_starve <= '0;
        end else begin
            case (r_state)
                SB_RUN:   if (flush_req) r_state <= SB_FLUSH;
                SB_FLUSH: if (w_empty)   r_state <= SB_RUN;
                default:  r_state <= SB_RUN;
            endcase
            if (w_drain || w_empty)
                r_starve <= '0;
            else if (w_load && r_starve != c_SCW'(STARVE_LIMIT))
                r_starve <= r_starve + 1'b1;
        end
    end

endmodule
`default_nettype wire
